// File: rtl/ray_gen.sv
// Camera ray generator: scans a WIDTH x HEIGHT frame in raster order and emits one
// unnormalised (x, y, z) direction per pixel as IEEE-754 single-precision words.
`timescale 1ns/1ps

module ray_gen #(
    parameter int SIZE   = 32,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int FOCAL  = 256
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2:0][SIZE-1:0] m_axis_result_tdata,
    output logic                 m_axis_result_tvalid,
    input  logic                 m_axis_result_tready,
    output logic                 m_axis_result_tlast,
    output logic [15:0]          pix_x,
    output logic [15:0]          pix_y
);

    // 25 bits signed covers every component: |v| < 2^24.
    localparam int CW = 25;
    localparam logic [15:0]          LAST_X = 16'(WIDTH - 1);
    localparam logic [15:0]          LAST_Y = 16'(HEIGHT - 1);
    localparam logic signed [CW-1:0] HALF_W = CW'(WIDTH / 2);
    localparam logic signed [CW-1:0] HALF_H = CW'(HEIGHT / 2);
    localparam logic signed [CW-1:0] NEG_F  = CW'(-FOCAL);

    generate
        if (SIZE != 32) begin : g_size_check
            $error("ray_gen supports only SIZE = 32");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [15:0]           px_p0, py_p0;
    logic [2:0][SIZE-1:0]  tdata_p0;
    logic                  tlast_p0, vld_p0, busy_p0, done_p0;

    logic                  hs;
    logic [15:0]           nxt_px, nxt_py;
    logic                  nxt_last;
    logic signed [CW-1:0]  x_int, y_int;
    logic [2:0][SIZE-1:0]  nxt_data;

    // Exact integer-to-float: the leading one becomes the hidden bit, so no rounding.
    function automatic logic [31:0] int_to_float(input logic signed [CW-1:0] v);
        logic          sign;
        logic [CW-2:0] mag;
        logic [CW-2:0] norm;
        logic [4:0]    p;
        sign = v[CW-1];
        mag  = sign ? (CW-1)'(-v) : v[CW-2:0];
        p    = '0;
        for (int i = 0; i < CW - 1; i++) begin
            if (mag[i]) p = 5'(i);
        end
        norm = mag << (5'd23 - p);
        if (mag == '0) return 32'h0000_0000;
        return {sign, 8'd127 + {3'b000, p}, norm[22:0]};
    endfunction

    // Next pixel: (0,0) when starting from IDLE, raster successor while running.
    always_comb begin
        hs     = vld_p0 && m_axis_result_tready;
        nxt_px = '0;
        nxt_py = '0;
        if (state == RUN) begin
            if (px_p0 == LAST_X) begin
                nxt_py = py_p0 + 16'd1;
            end else begin
                nxt_px = px_p0 + 16'd1;
                nxt_py = py_p0;
            end
        end
        nxt_last    = (nxt_px == LAST_X) && (nxt_py == LAST_Y);
        x_int       = $signed({9'd0, nxt_px}) - HALF_W;
        y_int       = HALF_H - $signed({9'd0, nxt_py});
        nxt_data[0] = SIZE'(int_to_float(x_int));
        nxt_data[1] = SIZE'(int_to_float(y_int));
        nxt_data[2] = SIZE'(int_to_float(NEG_F));
    end

    // Output register stage p0: reloads only on start or on a handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            px_p0    <= '0;
            py_p0    <= '0;
            tdata_p0 <= '0;
            tlast_p0 <= 1'b0;
            vld_p0   <= 1'b0;
            busy_p0  <= 1'b0;
            done_p0  <= 1'b0;
        end else begin
            done_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy_p0  <= 1'b1;
                        vld_p0   <= 1'b1;
                        px_p0    <= nxt_px;
                        py_p0    <= nxt_py;
                        tdata_p0 <= nxt_data;
                        tlast_p0 <= nxt_last;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (tlast_p0) begin
                            state    <= IDLE;
                            busy_p0  <= 1'b0;
                            vld_p0   <= 1'b0;
                            tlast_p0 <= 1'b0;
                            done_p0  <= 1'b1;
                            px_p0    <= '0;
                            py_p0    <= '0;
                        end else begin
                            px_p0    <= nxt_px;
                            py_p0    <= nxt_py;
                            tdata_p0 <= nxt_data;
                            tlast_p0 <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                 = busy_p0;
    assign done                 = done_p0;
    assign m_axis_result_tdata  = tdata_p0;
    assign m_axis_result_tvalid = vld_p0;
    assign m_axis_result_tlast  = tlast_p0;
    assign pix_x                = px_p0;
    assign pix_y                = py_p0;

endmodule

// File: tb/tb_ray_gen.sv
// Directed bench for ray_gen: small 4x2 frame, default 320x240 frame and a 64x64
// sweep against an arithmetic int-to-float reference.
`timescale 1ns/1ps

module tb_ray_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit big_done = 1'b0;

    // Small frame: 4x2, focal 2
    logic             s_rstn, s_start, s_tready;
    logic             s_busy, s_done, s_valid, s_last;
    logic [2:0][31:0] s_data;
    logic [15:0]      s_px, s_py;

    // Sweep frame: 64x64, focal 64
    logic             w_start, w_tready;
    logic             w_busy, w_done, w_valid, w_last;
    logic [2:0][31:0] w_data;
    logic [15:0]      w_px, w_py;

    // Default frame: 320x240, focal 256
    logic             b_rstn, b_start, b_tready;
    logic             b_busy, b_done, b_valid, b_last;
    logic [2:0][31:0] b_data;
    logic [15:0]      b_px, b_py;

    ray_gen #(.SIZE(32), .WIDTH(4), .HEIGHT(2), .FOCAL(2)) u_small (
        .aclk(clk), .aresetn(s_rstn), .start(s_start), .busy(s_busy), .done(s_done),
        .m_axis_result_tdata(s_data), .m_axis_result_tvalid(s_valid),
        .m_axis_result_tready(s_tready), .m_axis_result_tlast(s_last),
        .pix_x(s_px), .pix_y(s_py)
    );

    ray_gen #(.SIZE(32), .WIDTH(64), .HEIGHT(64), .FOCAL(64)) u_sweep (
        .aclk(clk), .aresetn(s_rstn), .start(w_start), .busy(w_busy), .done(w_done),
        .m_axis_result_tdata(w_data), .m_axis_result_tvalid(w_valid),
        .m_axis_result_tready(w_tready), .m_axis_result_tlast(w_last),
        .pix_x(w_px), .pix_y(w_py)
    );

    ray_gen u_big (
        .aclk(clk), .aresetn(b_rstn), .start(b_start), .busy(b_busy), .done(b_done),
        .m_axis_result_tdata(b_data), .m_axis_result_tvalid(b_valid),
        .m_axis_result_tready(b_tready), .m_axis_result_tlast(b_last),
        .pix_x(b_px), .pix_y(b_py)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_float(input int v);
        int m, p, t;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        t = m;
        while (t > 1) begin
            t = t / 2;
            p++;
        end
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m - (1 << p)) * (1 << (23 - p)));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small_vec(input int idx);
        logic [31:0] ex, ey;
        case (idx % 4)
            0:       ex = 32'hC000_0000;
            1:       ex = 32'hBF80_0000;
            2:       ex = 32'h0000_0000;
            default: ex = 32'h3F80_0000;
        endcase
        ey = (idx < 4) ? 32'h3F80_0000 : 32'h0000_0000;
        check($sformatf("small_x[%0d]", idx), s_data[0], ex);
        check($sformatf("small_y[%0d]", idx), s_data[1], ey);
        check($sformatf("small_z[%0d]", idx), s_data[2], 32'hC000_0000);
        check($sformatf("small_px[%0d]", idx), 32'(s_px), 32'(idx % 4));
        check($sformatf("small_py[%0d]", idx), 32'(s_py), 32'(idx / 4));
        check($sformatf("small_last[%0d]", idx), 32'(s_last), 32'(idx == 7));
    endtask

    // Runs one small frame to its done pulse, checking every accepted vector in order.
    task automatic run_small(input bit rnd, input bit poke_start, input bit do_start);
        int               n_acc = 0;
        bit               stalled = 1'b0;
        bit               seen_done = 1'b0;
        logic [2:0][31:0] held;
        logic [15:0]      held_px;
        held    = '0;
        held_px = '0;
        if (do_start) begin
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
        end
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            if (s_done) begin
                seen_done = 1'b1;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(s_valid), 32'd1);
                    check("hold_x", s_data[0], held[0]);
                    check("hold_y", s_data[1], held[1]);
                    check("hold_px", 32'(s_px), 32'(held_px));
                end
                s_start  = poke_start && (cyc == 3);
                s_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s_valid && s_tready) begin
                    chk_small_vec(n_acc);
                    n_acc++;
                end
                stalled = s_valid && !s_tready;
                held    = s_data;
                held_px = s_px;
                tick();
            end
        end
        s_start = 1'b0;
        check("small_done_seen", 32'(seen_done), 32'd1);
        check("small_count", n_acc, 32'd8);
    endtask

    initial begin
        int  n;
        bit  seen;
        s_rstn   = 1'b0;
        s_start  = 1'b0;
        s_tready = 1'b0;
        w_start  = 1'b0;
        w_tready = 1'b1;
        repeat (3) tick();

        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        check("rst_last", 32'(s_last), 32'd0);
        check("rst_x", s_data[0], 32'd0);
        check("rst_px", 32'(s_px), 32'd0);
        s_rstn = 1'b1;
        repeat (2) tick();
        check("idle_valid", 32'(s_valid), 32'd0);

        // Back-to-back frame with tready held high
        s_tready = 1'b1;
        s_start  = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a_valid[%0d]", i), 32'(s_valid), 32'd1);
            check($sformatf("a_busy[%0d]", i), 32'(s_busy), 32'd1);
            chk_small_vec(i);
            tick();
        end
        check("a_valid_end", 32'(s_valid), 32'd0);
        check("a_busy_end", 32'(s_busy), 32'd0);
        check("a_done", 32'(s_done), 32'd1);
        tick();
        check("a_done_pulse", 32'(s_done), 32'd0);

        // Random backpressure
        run_small(1'b1, 1'b0, 1'b1);
        tick();
        // start pulse while running is ignored
        run_small(1'b0, 1'b1, 1'b1);
        tick();

        // start during the done cycle: one-cycle bubble, then a full frame
        run_small(1'b0, 1'b0, 1'b1);
        check("d_done_now", 32'(s_done), 32'd1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("d_restart_valid", 32'(s_valid), 32'd1);
        check("d_restart_px", 32'(s_px), 32'd0);
        run_small(1'b0, 1'b0, 1'b0);
        tick();

        // Reset mid-frame
        s_tready = 1'b1;
        s_start  = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (3) tick();
        check("mid_valid_pre", 32'(s_valid), 32'd1);
        s_rstn = 1'b0;
        #1;
        check("mid_valid", 32'(s_valid), 32'd0);
        check("mid_busy", 32'(s_busy), 32'd0);
        check("mid_last", 32'(s_last), 32'd0);
        check("mid_x", s_data[0], 32'd0);
        check("mid_y", s_data[1], 32'd0);
        check("mid_z", s_data[2], 32'd0);
        check("mid_px", 32'(s_px), 32'd0);
        check("mid_py", 32'(s_py), 32'd0);
        tick();
        s_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_idle", 32'(s_valid), 32'd0);
        end
        run_small(1'b0, 1'b0, 1'b1);
        tick();

        // 64x64 sweep against the reference conversion
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 5000 && n < 4096; cyc++) begin
            if (w_valid) begin
                check($sformatf("sw_x[%0d]", n), w_data[0], ref_float((n % 64) - 32));
                check($sformatf("sw_y[%0d]", n), w_data[1], ref_float(32 - (n / 64)));
                check($sformatf("sw_z[%0d]", n), w_data[2], ref_float(-64));
                check($sformatf("sw_px[%0d]", n), 32'(w_px), 32'(n % 64));
                check($sformatf("sw_py[%0d]", n), 32'(w_py), 32'(n / 64));
                check($sformatf("sw_last[%0d]", n), 32'(w_last), 32'(n == 4095));
                n++;
            end
            tick();
        end
        check("sw_count", n, 32'd4096);
        check("sw_done", 32'(w_done), 32'd1);

        seen = big_done;
        for (int i = 0; i < 100000 && !seen; i++) begin
            @(posedge clk);
            seen = big_done;
        end
        check("big_finished", 32'(seen), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int nb;
        bit got_last;
        b_rstn   = 1'b0;
        b_start  = 1'b0;
        b_tready = 1'b1;
        repeat (4) tick();
        b_rstn = 1'b1;
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("big_first_valid", 32'(b_valid), 32'd1);
        check("big_first_x", b_data[0], 32'hC320_0000);
        check("big_first_y", b_data[1], 32'h42F0_0000);
        check("big_first_z", b_data[2], 32'hC380_0000);
        nb       = 0;
        got_last = 1'b0;
        for (int cyc = 0; cyc < 80000 && !got_last; cyc++) begin
            if (b_valid) begin
                nb++;
                if (b_last) begin
                    got_last = 1'b1;
                    check("big_last_x", b_data[0], 32'h431F_0000);
                    check("big_last_y", b_data[1], 32'hC2EE_0000);
                    check("big_last_z", b_data[2], 32'hC380_0000);
                    check("big_last_px", 32'(b_px), 32'd319);
                    check("big_last_py", 32'(b_py), 32'd239);
                end
            end
            tick();
        end
        check("big_last_seen", 32'(got_last), 32'd1);
        check("big_count", nb, 32'd76800);
        check("big_done", 32'(b_done), 32'd1);
        big_done = 1'b1;
    end

endmodule

// File: doc/ray_gen.md
# ray_gen

Per-frame camera ray generator that feeds `vec_unit`, the upstream stage of the ray normalisation path.
- On a `start` pulse it scans every pixel of a WIDTH×HEIGHT frame in raster order.
- For each pixel it emits one unnormalised direction vector (x, y, z) as three IEEE-754 single-precision floats on an AXI-Stream-style master port.
- The port connects directly to `vec_unit`'s slave port.
- Integer-to-float conversion is done in-block, exactly, with no float IP.

## Interface
- SIZE, 32, float width; only 32 is supported.
- WIDTH, 320, pixels per row; even, 2..65534.
- HEIGHT, 240, rows per frame; even, 2..65534.
- FOCAL, 256, focal distance in pixels; 1..2^23.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  frame start request, sampled only in IDLE.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last vector of a frame is accepted.
- m_axis_result_tdata  out  [2:0][SIZE-1:0]  [0]=x, [1]=y, [2]=z float words.
- m_axis_result_tvalid  out  1  vector valid.
- m_axis_result_tready  in  1  downstream ready.
- m_axis_result_tlast  out  1  high with the last pixel of the frame, px=WIDTH-1 and py=HEIGHT-1.
- pix_x  out  16  column of the current output vector, qualified by tvalid.
- pix_y  out  16  row of the current output vector, qualified by tvalid.

## Operation
- FSM states: IDLE, RUN.
  - IDLE + start → RUN. Counters px=0, py=0. The output register loads pixel (0,0).
  - RUN: a handshake is tvalid && tready. On each handshake, advance px. When px wraps from WIDTH-1 to 0, increment py.
  - RUN + handshake with tlast=1 → IDLE. tvalid drops and done pulses.
  - start is ignored in RUN.
- Component integers per pixel (signed):
  - x = px − WIDTH/2
  - y = HEIGHT/2 − py
  - z = −FOCAL
- Float conversion, per component:
  - sign = MSB of the signed integer; mag = |v|.
  - v=0 → 0x00000000.
  - Otherwise p = index of the leading one of mag. Exponent = 127+p. Mantissa = (mag << (23−p))[22:0].
  - |v| < 2^24 always holds, so the conversion is exact and needs no rounding.
- Output register holds tdata, tlast, pix_x and pix_y.
  - On a handshake it reloads with the next pixel's values in the same edge, computed combinationally from the next counter values.
  - While tvalid && !tready, all outputs are held stable.
- Reset asserted at any time, including mid-frame:
  - Go to IDLE and clear the counters.
  - tvalid=0, tlast=0, busy=0, done=0, tdata=0, pix_x=0, pix_y=0.
  - No partial frame resumes after reset; a new start is required.

## Timing
- start high at edge N in IDLE → at N+1: tvalid=1, busy=1, data is pixel (0,0).
- Throughput is one vector per cycle while tready=1. With tready held high, a frame takes WIDTH×HEIGHT cycles from the first tvalid.
- Last handshake at edge M → at M+1: tvalid=0, busy=0, done=1. At M+2: done=0.
- start is accepted at M+1 (IDLE) → the next frame's first vector is valid at M+2. This gives a one-cycle bubble between frames.
- start coincident with reset deassertion: reset dominates; start is sampled from the first edge after aresetn=1.
- tready may toggle every cycle. Data must never advance without a handshake, and a pixel must never be duplicated.

## Test plan
- Reset: assert aresetn=0 mid-frame with tready=1 → next sample shows tvalid=0, busy=0, tdata=0, pix_x=pix_y=0. After release, no output until start.
- Small frame, WIDTH=4, HEIGHT=2, FOCAL=2, tready=1, start pulse → 8 vectors in 8 consecutive cycles:
  - x sequence 0xC0000000, 0xBF800000, 0x00000000, 0x3F800000.
  - y=0x3F800000 for row 0 and 0x00000000 for row 1.
  - z=0xC0000000 throughout.
  - tlast only on the 8th vector; done one cycle later.
- Default parameters, tready=1 → first vector {0xC3200000, 0x42F00000, 0xC3800000}. Last vector (319,239) {0x431F0000, 0xC2EE0000, 0xC3800000} with tlast=1. Total 76800 handshakes.
- Backpressure: small frame with tready driven by a random 50% pattern → outputs stable whenever tvalid && !tready. The sequence of accepted vectors is identical to the tready=1 run.
- Start handling: start pulse during RUN → no effect, count still 8. start asserted the cycle done is high → new frame's first vector valid the following cycle.
- Conversion sweep: a model check of every emitted word against a reference int→float conversion over a 64×64 frame → zero mismatches, including 0 → 0x00000000 and the ±power-of-two boundaries.
